ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Instruction fetch stage of the single-cycle MIPS datapath, directly upstream of the main control decoder. Holds the program counter, fetches one 32-bit word per instruction from instruction memory over a req/valid handshake, and presents the instruction (and its opcode field, `instr[31:26]`) to the decoder and datapath until the instruction commits. On commit it selects the next PC from PC+4 or the beq target, using the decoder's `branch` output and the ALU `zero` flag, and counts retired instructions.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  byte address of the word requested; always equals `pc`.
- `imem_rdata`  in  32  instruction word; sampled only when `imem_valid`=1 in FETCH.
- `imem_valid`  in  1  memory response strobe.
- `branch`  in  1  from control decoder (beq).
- `zero`  in  1  from ALU.
- `stall`  in  1  holds the current instruction; blocks commit.
- `instr`  out  32  registered instruction word.
- `opcode`  out  6  equals `instr[31:26]`; feeds the control decoder.
- `instr_valid`  out  1  `instr` is valid and being executed.
- `pc`  out  32  address of the current instruction.
- `pc_plus4`  out  32  `pc + 4`, combinational.
- `retired`  out  32  count of committed instructions.

## Operation
- FSM states: START, FETCH, EXEC.
  - START: entered on reset. `imem_req`=0. Next state is always FETCH.
  - FETCH: `imem_req`=1 and `imem_addr`=`pc`, both held stable until `imem_valid`=1.
    - On `imem_valid`=1: `instr`<=`imem_rdata`, go to EXEC.
  - EXEC: `instr_valid`=1, `imem_req`=0.
    - If `stall`=1: hold all state.
    - Else commit:
      - `pc`<=`target` if `branch & zero`, else `pc_plus4`.
      - `retired`<=`retired`+1.
      - Go to FETCH.
- `target` = `pc_plus4` + (sign-extended `instr[15:0]` << 2). All 32-bit arithmetic is modulo 2^32; `pc` wraps from 32'hFFFF_FFFC to 0 without error.
- `branch` and `zero` are sampled only on the commit edge; their values in other cycles are ignored.
- `imem_valid` outside FETCH is ignored.
- `retired` wraps from 2^32-1 to 0.
- `pc[1:0]` is always 00 by construction. No alignment checking.

## Timing
- Reset values: `pc`=`RESET_PC`, `instr`=0, `opcode`=0, `instr_valid`=0, `imem_req`=0, `retired`=0, state=START.
- First request: `imem_req`=1 in the second cycle after the reset edge. The START state inserts one idle cycle.
- Memory protocol:
  - Memory must drop any outstanding request when it sees `imem_req`=0.
  - A response may arrive in the same cycle as the request (zero-wait).
- Latency: `instr_valid` rises on the edge that samples `imem_valid`=1.
- Minimum throughput: one instruction per 2 cycles (FETCH with zero-wait response, then EXEC with `stall`=0).
- Each extra memory wait cycle adds one cycle; each `stall` cycle adds one cycle.
- `instr` and `pc` are constant for the whole EXEC interval, including stalls.
- Reset mid-operation (any state, including an outstanding FETCH): all registers return to reset values on that edge; the request is abandoned and `retired` is cleared.
- Simultaneous `reset` with `imem_valid`, or with commit: reset wins; nothing is captured and nothing is counted.

## Test plan
- Reset, then zero-wait memory returning 32'h8C08_0004 (lw) at addr 0: `imem_req` rises at cycle 2. `instr_valid`=1 with `opcode`=6'h23. After commit with `stall`=0, `pc`=4 and `retired`=1.
- Taken beq: `instr`=32'h1000_FFFF at `pc`=32'h0000_0040 with `branch`=1, `zero`=1. Next `pc`=32'h0000_0040 (`target` = 0x44 - 4). Same instruction with `zero`=0: next `pc`=32'h0000_0044.
- Memory wait: `imem_valid` delayed 3 cycles. `imem_req`/`imem_addr` stay stable for 4 FETCH cycles; `instr_valid` stays 0 until the capture edge.
- Stall: hold `stall`=1 for 5 EXEC cycles. `instr`, `pc`, and `retired` are unchanged; commit occurs on the first edge with `stall`=0.
- Wrap: `RESET_PC`=32'hFFFF_FFFC, non-branch instruction. After commit, `pc`=0.
- Reset asserted during FETCH with `imem_valid`=1 in the same cycle: `instr`=0, `instr_valid`=0, `pc`=`RESET_PC`, `retired`=0, `imem_req`=0 on the next cycle.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per instruction over a
// req/valid handshake, holds it until commit, then picks PC+4 or the beq target.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_valid_i,
  input  logic        branch_i,
  input  logic        zero_i,
  input  logic        stall_i,
  output logic [31:0] instr_o,
  output logic [5:0]  opcode_o,
  output logic        instr_valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] retired_o
);

  typedef enum logic [1:0] {
    START = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] retired_q, retired_d;
  logic        req_q, req_d;
  logic        ivalid_q, ivalid_d;

  logic [31:0] pc_plus4;
  logic [31:0] target;

  assign pc_plus4 = pc_q + 32'd4;
  assign target   = pc_plus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  // req and instr_valid are registered alongside the state so they are
  // asserted exactly while the FSM sits in FETCH and EXEC respectively.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    req_d     = req_q;
    ivalid_d  = ivalid_q;
    case (state_q)
      START: begin
        state_d = FETCH;
        req_d   = 1'b1;
      end
      FETCH: begin
        if (imem_valid_i) begin
          instr_d  = imem_rdata_i;
          state_d  = EXEC;
          req_d    = 1'b0;
          ivalid_d = 1'b1;
        end
      end
      EXEC: begin
        if (!stall_i) begin
          pc_d      = (branch_i && zero_i) ? target : pc_plus4;
          retired_d = retired_q + 32'd1;
          state_d   = FETCH;
          req_d     = 1'b1;
          ivalid_d  = 1'b0;
        end
      end
      default: begin
        state_d  = START;
        req_d    = 1'b0;
        ivalid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= START;
      pc_q      <= RESET_PC;
      instr_q   <= 32'd0;
      retired_q <= 32'd0;
      req_q     <= 1'b0;
      ivalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      req_q     <= req_d;
      ivalid_q  <= ivalid_d;
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign instr_o       = instr_q;
  assign opcode_o      = instr_q[31:26];
  assign instr_valid_o = ivalid_q;
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_plus4;
  assign retired_o     = retired_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized bench for ifetch_unit against a transaction-level PC/retire model;
// a second instance with a top-of-memory reset PC exercises PC wrap.
module tb_ifetch_unit;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        imem_req_o, imem_valid_i;
  logic [31:0] imem_addr_o, imem_rdata_i;
  logic        branch_i, zero_i, stall_i;
  logic [31:0] instr_o, pc_o, pc_plus4_o, retired_o;
  logic [5:0]  opcode_o;
  logic        instr_valid_o;

  logic        req2, ivalid2;
  logic [31:0] addr2, instr2, pc2, pc_plus4_2, retired2;
  logic [5:0]  opcode2;

  int checks = 0;
  int failures = 0;
  logic [31:0] mPc, mRetired;

  always #5 clk_i = ~clk_i;

  ifetch_unit dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_rdata_i(imem_rdata_i), .imem_valid_i(imem_valid_i),
    .branch_i(branch_i), .zero_i(zero_i), .stall_i(stall_i),
    .instr_o(instr_o), .opcode_o(opcode_o), .instr_valid_o(instr_valid_o),
    .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .retired_o(retired_o)
  );

  ifetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk_i(clk_i), .reset_i(reset_i),
    .imem_req_o(req2), .imem_addr_o(addr2),
    .imem_rdata_i(imem_rdata_i), .imem_valid_i(imem_valid_i),
    .branch_i(branch_i), .zero_i(zero_i), .stall_i(stall_i),
    .instr_o(instr2), .opcode_o(opcode2), .instr_valid_o(ivalid2),
    .pc_o(pc2), .pc_plus4_o(pc_plus4_2), .retired_o(retired2)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // A beq moves the PC by the signed word offset relative to the following instruction.
  function automatic logic [31:0] modelNextPc(input logic [31:0] pc, input logic [31:0] word,
                                              input logic taken);
    longint off;
    off = taken ? longint'($signed(word[15:0])) * 4 : 0;
    return 32'(longint'(pc) + 4 + off);
  endfunction

  task automatic test_reset();
    reset_i = 1'b1; imem_valid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    stall_i = 1'b0; branch_i = 1'b0; zero_i = 1'b0;
    tick(); tick();
    checks++; if (imem_req_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_req got=%b exp=0", imem_req_o); end
    checks++; if (instr_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_ivalid got=%b exp=0", instr_valid_o); end
    checks++; if (pc_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_pc got=%h exp=0", pc_o); end
    checks++; if (instr_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_instr got=%h exp=0", instr_o); end
    checks++; if (opcode_o !== 6'h0) begin failures++; $display("[TB] FAIL reset_opcode got=%h exp=0", opcode_o); end
    checks++; if (retired_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_retired got=%h exp=0", retired_o); end
    checks++; if (pc2 !== 32'hFFFF_FFFC) begin failures++; $display("[TB] FAIL reset_pc2 got=%h exp=fffffffc", pc2); end
    reset_i = 1'b0;
    tick();
    checks++; if (imem_req_o !== 1'b1) begin failures++; $display("[TB] FAIL first_req got=%b exp=1", imem_req_o); end
    checks++; if (instr_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL start_ignores_valid got=%b exp=0", instr_valid_o); end
    checks++; if (instr_o !== 32'h0) begin failures++; $display("[TB] FAIL start_no_capture got=%h exp=0", instr_o); end
    imem_valid_i = 1'b0;
    mPc = 32'h0; mRetired = 32'h0;
  endtask

  // Entered just after the edge that put the unit in FETCH; leaves it in FETCH again.
  task automatic test_instr(input logic [31:0] word, input int waits, input int stalls,
                            input logic br, input logic zr);
    for (int i = 0; i <= waits; i++) begin
      checks++; if (imem_req_o !== 1'b1) begin failures++; $display("[TB] FAIL fetch_req got=%b exp=1", imem_req_o); end
      checks++; if (imem_addr_o !== mPc) begin failures++; $display("[TB] FAIL fetch_addr got=%h exp=%h", imem_addr_o, mPc); end
      checks++; if (instr_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL fetch_ivalid got=%b exp=0", instr_valid_o); end
      imem_valid_i = (i == waits);
      imem_rdata_i = (i == waits) ? word : $urandom;
      branch_i = 1'($urandom); zero_i = 1'($urandom);
      tick();
    end
    checks++; if (instr_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL exec_ivalid got=%b exp=1", instr_valid_o); end
    checks++; if (instr_o !== word) begin failures++; $display("[TB] FAIL exec_instr got=%h exp=%h", instr_o, word); end
    checks++; if (opcode_o !== word[31:26]) begin failures++; $display("[TB] FAIL exec_opcode got=%h exp=%h", opcode_o, word[31:26]); end
    checks++; if (pc_o !== mPc) begin failures++; $display("[TB] FAIL exec_pc got=%h exp=%h", pc_o, mPc); end
    checks++; if (pc_plus4_o !== mPc + 32'd4) begin failures++; $display("[TB] FAIL exec_pc4 got=%h exp=%h", pc_plus4_o, mPc + 32'd4); end
    checks++; if (imem_req_o !== 1'b0) begin failures++; $display("[TB] FAIL exec_req got=%b exp=0", imem_req_o); end
    checks++; if (retired_o !== mRetired) begin failures++; $display("[TB] FAIL exec_retired got=%h exp=%h", retired_o, mRetired); end
    for (int j = 0; j < stalls; j++) begin
      stall_i = 1'b1; branch_i = 1'($urandom); zero_i = 1'($urandom);
      imem_valid_i = 1'($urandom); imem_rdata_i = $urandom;
      tick();
      checks++; if (instr_o !== word) begin failures++; $display("[TB] FAIL stall_instr got=%h exp=%h", instr_o, word); end
      checks++; if (pc_o !== mPc) begin failures++; $display("[TB] FAIL stall_pc got=%h exp=%h", pc_o, mPc); end
      checks++; if (retired_o !== mRetired) begin failures++; $display("[TB] FAIL stall_retired got=%h exp=%h", retired_o, mRetired); end
      checks++; if (instr_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL stall_ivalid got=%b exp=1", instr_valid_o); end
    end
    stall_i = 1'b0; branch_i = br; zero_i = zr;
    imem_valid_i = 1'($urandom); imem_rdata_i = $urandom;
    tick();
    mPc = modelNextPc(mPc, word, br && zr);
    mRetired = mRetired + 32'd1;
    imem_valid_i = 1'b0;
    checks++; if (instr_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL commit_ivalid got=%b exp=0", instr_valid_o); end
    checks++; if (imem_req_o !== 1'b1) begin failures++; $display("[TB] FAIL commit_req got=%b exp=1", imem_req_o); end
    checks++; if (pc_o !== mPc) begin failures++; $display("[TB] FAIL commit_pc got=%h exp=%h", pc_o, mPc); end
    checks++; if (retired_o !== mRetired) begin failures++; $display("[TB] FAIL commit_retired got=%h exp=%h", retired_o, mRetired); end
  endtask

  task automatic test_lw();
    test_instr(32'h8C08_0004, 0, 0, 1'b0, 1'b0);
    checks++; if (pc_o !== 32'h4) begin failures++; $display("[TB] FAIL lw_pc got=%h exp=4", pc_o); end
    checks++; if (retired_o !== 32'h1) begin failures++; $display("[TB] FAIL lw_retired got=%h exp=1", retired_o); end
  endtask

  task automatic test_branch();
    test_instr(32'h1000_000E, 0, 0, 1'b1, 1'b1);
    checks++; if (pc_o !== 32'h40) begin failures++; $display("[TB] FAIL beq_fwd got=%h exp=40", pc_o); end
    test_instr(32'h1000_FFFF, 0, 0, 1'b1, 1'b1);
    checks++; if (pc_o !== 32'h40) begin failures++; $display("[TB] FAIL beq_taken got=%h exp=40", pc_o); end
    test_instr(32'h1000_FFFF, 0, 0, 1'b1, 1'b0);
    checks++; if (pc_o !== 32'h44) begin failures++; $display("[TB] FAIL beq_not_taken got=%h exp=44", pc_o); end
  endtask

  task automatic test_mem_wait();
    test_instr(32'h0110_4820, 3, 0, 1'b1, 1'b1);
  endtask

  task automatic test_stall();
    test_instr(32'h1000_0010, 0, 5, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      test_instr($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_reset_fetch();
    reset_i = 1'b1; imem_valid_i = 1'b1; imem_rdata_i = 32'hCAFE_F00D;
    tick();
    checks++; if (instr_o !== 32'h0) begin failures++; $display("[TB] FAIL rstf_instr got=%h exp=0", instr_o); end
    checks++; if (instr_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL rstf_ivalid got=%b exp=0", instr_valid_o); end
    checks++; if (pc_o !== 32'h0) begin failures++; $display("[TB] FAIL rstf_pc got=%h exp=0", pc_o); end
    checks++; if (retired_o !== 32'h0) begin failures++; $display("[TB] FAIL rstf_retired got=%h exp=0", retired_o); end
    checks++; if (imem_req_o !== 1'b0) begin failures++; $display("[TB] FAIL rstf_req got=%b exp=0", imem_req_o); end
    reset_i = 1'b0; imem_valid_i = 1'b0;
    tick();
    mPc = 32'h0; mRetired = 32'h0;
    test_instr(32'h2008_0001, 1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_commit();
    imem_valid_i = 1'b1; imem_rdata_i = 32'h1000_0004;
    tick();
    imem_valid_i = 1'b0; reset_i = 1'b1; stall_i = 1'b0; branch_i = 1'b1; zero_i = 1'b1;
    tick();
    checks++; if (retired_o !== 32'h0) begin failures++; $display("[TB] FAIL rstc_retired got=%h exp=0", retired_o); end
    checks++; if (pc_o !== 32'h0) begin failures++; $display("[TB] FAIL rstc_pc got=%h exp=0", pc_o); end
    checks++; if (instr_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL rstc_ivalid got=%b exp=0", instr_valid_o); end
    reset_i = 1'b0; branch_i = 1'b0; zero_i = 1'b0;
    tick();
    mPc = 32'h0; mRetired = 32'h0;
  endtask

  task automatic test_wrap();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    tick();
    checks++; if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFFC) begin failures++; $display("[TB] FAIL wrap_fetch got=%b/%h exp=1/fffffffc", req2, addr2); end
    imem_valid_i = 1'b1; imem_rdata_i = 32'h0000_0020;
    tick();
    imem_valid_i = 1'b0; stall_i = 1'b0; branch_i = 1'b0; zero_i = 1'b1;
    checks++; if (pc2 !== 32'hFFFF_FFFC) begin failures++; $display("[TB] FAIL wrap_exec_pc got=%h exp=fffffffc", pc2); end
    checks++; if (pc_plus4_2 !== 32'h0) begin failures++; $display("[TB] FAIL wrap_pc4 got=%h exp=0", pc_plus4_2); end
    checks++; if (ivalid2 !== 1'b1 || instr2 !== 32'h20 || opcode2 !== 6'h0) begin failures++; $display("[TB] FAIL wrap_instr got=%b/%h exp=1/00000020", ivalid2, instr2); end
    tick();
    checks++; if (pc2 !== 32'h0) begin failures++; $display("[TB] FAIL wrap_pc got=%h exp=0", pc2); end
    checks++; if (retired2 !== 32'h1) begin failures++; $display("[TB] FAIL wrap_retired got=%h exp=1", retired2); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_lw();
    test_branch();
    test_mem_wait();
    test_stall();
    test_random();
    test_reset_fetch();
    test_reset_commit();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
